// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared state encoding and coin values for the vending controller
package vend_pkg;

  typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} vend_state_e;

  localparam int unsigned NICKEL  = 5;
  localparam int unsigned DIME    = 10;
  localparam int unsigned QUARTER = 25;

endpackage

// File: rtl/change_pacer.sv
// rtl/change_pacer.sv - paces change payout: tick on start, then one tick every PULSE_GAP cycles
module change_pacer #(
  parameter int unsigned PULSE_GAP = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic stop,
  output logic tick
);

  localparam int unsigned GW = $clog2(PULSE_GAP);
  localparam logic [GW-1:0] LAST = GW'(PULSE_GAP - 1);

  logic [GW-1:0] cnt;
  logic          active;

  // tick is consumed by a register in the controller, so a tick here lands one cycle later
  assign tick = start | (active & (cnt == LAST));

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt    <= '0;
      active <= 1'b0;
    end else if (start) begin
      cnt    <= '0;
      active <= 1'b1;
    end else if (stop) begin
      cnt    <= '0;
      active <= 1'b0;
    end else if (active) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vend_controller.sv
// rtl/vend_controller.sv - vending transaction sequencer: credit, vend, paced change
// Optional idle auto-refund built when VEND_TIMEOUT_EN is defined.
module vend_controller
  import vend_pkg::*;
#(
  parameter int unsigned PRICE      = 75,
  parameter int unsigned MAX_CREDIT = 200,
  parameter int unsigned CREDIT_W   = 8,
  parameter int unsigned PULSE_GAP  = 4,
  parameter int unsigned TIMEOUT    = 1000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_n,
  input  logic                coin_d,
  input  logic                coin_q,
  input  logic                sel_p,
  input  logic                cancel_p,
  output logic [CREDIT_W-1:0] credit,
  output logic                dispense,
  output logic                change_n,
  output logic                coin_reject,
  output logic                busy
);

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W:0]   MAX_C   = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] STEP_C  = CREDIT_W'(NICKEL);

  if ((PRICE % 5) != 0 || PRICE > MAX_CREDIT || (MAX_CREDIT % 5) != 0 ||
      MAX_CREDIT >= 2**CREDIT_W || PULSE_GAP < 2 || TIMEOUT < 2) begin : g_bad_params
    $error("vend_controller: illegal parameter set");
  end

  vend_state_e         state, state_nx;
  logic [CREDIT_W-1:0] credit_nx, coin_val;
  logic [CREDIT_W:0]   sum;
  logic                dispense_nx, change_nx, reject_nx;
  logic                any_coin, any_pulse;
  logic                pacer_start, pacer_stop, tick, timeout_hit;

  assign any_coin  = coin_n | coin_d | coin_q;
  assign any_pulse = any_coin | sel_p | cancel_p;

  always_comb begin
    coin_val = '0;
    if (coin_q)      coin_val = CREDIT_W'(QUARTER);
    else if (coin_d) coin_val = CREDIT_W'(DIME);
    else if (coin_n) coin_val = CREDIT_W'(NICKEL);
  end

  assign sum = {1'b0, credit} + {1'b0, coin_val};

`ifdef VEND_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TO_ARM = TW'(TIMEOUT - 2);
  logic [TW-1:0] idle_cnt;

  always_ff @(posedge clk) begin
    if (!reset || state != COLLECT || any_pulse) idle_cnt <= '0;
    else                                         idle_cnt <= idle_cnt + 1'b1;
  end

  // armed one count early so the refund starts in the cycle the count reaches TIMEOUT-1
  assign timeout_hit = (state == COLLECT) && !any_pulse && (idle_cnt == TO_ARM);
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_nx    = state;
    credit_nx   = credit;
    dispense_nx = 1'b0;
    change_nx   = 1'b0;
    reject_nx   = any_coin;
    pacer_start = 1'b0;
    pacer_stop  = 1'b0;
    case (state)
      IDLE, COLLECT: begin
        if (cancel_p) begin
          if (credit != '0) begin
            state_nx    = CHANGE;
            pacer_start = 1'b1;
          end
        end else if (sel_p) begin
          if (credit >= PRICE_C) begin
            state_nx    = VEND;
            dispense_nx = 1'b1;
            credit_nx   = credit - PRICE_C;
          end
        end else if (any_coin) begin
          if (sum <= MAX_C) begin
            state_nx  = COLLECT;
            credit_nx = sum[CREDIT_W-1:0];
            // only the highest coin is taken; any lower coin in the same cycle goes back
            reject_nx = coin_q ? (coin_d | coin_n) : (coin_d & coin_n);
          end
        end else if (timeout_hit) begin
          state_nx    = CHANGE;
          pacer_start = 1'b1;
        end
      end
      VEND: begin
        if (credit != '0) begin
          state_nx    = CHANGE;
          pacer_start = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      CHANGE: begin
        if (credit == '0) begin
          state_nx   = IDLE;
          pacer_stop = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (tick) begin
      change_nx = 1'b1;
      credit_nx = credit - STEP_C;
    end
  end

  change_pacer #(.PULSE_GAP(PULSE_GAP)) u_pacer (
    .clk   (clk),
    .reset (reset),
    .start (pacer_start),
    .stop  (pacer_stop),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      credit      <= '0;
      dispense    <= 1'b0;
      change_n    <= 1'b0;
      coin_reject <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nx;
      credit      <= credit_nx;
      dispense    <= dispense_nx;
      change_n    <= change_nx;
      coin_reject <= reject_nx;
      busy        <= (state_nx == VEND) || (state_nx == CHANGE);
    end
  end

endmodule

// File: tb/tb_vend_controller.sv
// tb/tb_vend_controller.sv - directed self-checking bench for vend_controller
module tb_vend_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       coin_n = 1'b0, coin_d = 1'b0, coin_q = 1'b0, sel_p = 1'b0, cancel_p = 1'b0;
  logic [7:0] credit;
  logic       dispense, change_n, coin_reject, busy;
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  vend_controller #(
    .PRICE(75), .MAX_CREDIT(200), .CREDIT_W(8), .PULSE_GAP(4), .TIMEOUT(16)
  ) dut (
    .clk(clk), .reset(reset),
    .coin_n(coin_n), .coin_d(coin_d), .coin_q(coin_q), .sel_p(sel_p), .cancel_p(cancel_p),
    .credit(credit), .dispense(dispense), .change_n(change_n),
    .coin_reject(coin_reject), .busy(busy)
  );

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // drive one cycle of button pulses; returns observing the t+1 outputs
  task automatic pulse(input logic n, input logic d, input logic q, input logic s, input logic c);
    coin_n = n; coin_d = d; coin_q = q; sel_p = s; cancel_p = c;
    step();
    coin_n = 0; coin_d = 0; coin_q = 0; sel_p = 0; cancel_p = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step(2);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({credit, busy, dispense, change_n, coin_reject} !== 12'h000) begin
      fails++;
      $display("FAIL reset_outputs: got credit=%0d busy=%b disp=%b chg=%b rej=%b, expected all 0",
               credit, busy, dispense, change_n, coin_reject);
    end
  endtask

  task automatic test_exact_vend();
    int exp_credit;
    int chg_seen;
    do_reset();
    exp_credit = 0;
    for (int i = 0; i < 3; i++) begin
      pulse(0, 0, 1, 0, 0);
      exp_credit += 25;
      tests++;
      if (credit !== exp_credit[7:0] || coin_reject !== 1'b0) begin
        fails++;
        $display("FAIL exact_credit_%0d: got credit=%0d rej=%b, expected credit=%0d rej=0",
                 i, credit, coin_reject, exp_credit);
      end
      step(2);
    end
    pulse(0, 0, 0, 1, 0);
    tests++;
    if (dispense !== 1'b1 || busy !== 1'b1 || credit !== 8'd0) begin
      fails++;
      $display("FAIL exact_vend: got disp=%b busy=%b credit=%0d, expected 1 1 0", dispense, busy, credit);
    end
    chg_seen = 0;
    step();
    tests++;
    if (dispense !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL exact_idle: got disp=%b busy=%b, expected 0 0", dispense, busy);
    end
    for (int i = 0; i < 10; i++) begin
      if (change_n === 1'b1) chg_seen++;
      step();
    end
    tests++;
    if (chg_seen !== 0) begin
      fails++;
      $display("FAIL exact_no_change: got %0d change pulses, expected 0", chg_seen);
    end
  endtask

  task automatic test_vend_change();
    int exp_credit;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      pulse(0, 0, 1, 0, 0);
      step(2);
    end
    pulse(0, 0, 0, 1, 0);
    tests++;
    if (dispense !== 1'b1 || credit !== 8'd25 || change_n !== 1'b0) begin
      fails++;
      $display("FAIL change_vend: got disp=%b credit=%0d chg=%b, expected 1 25 0", dispense, credit, change_n);
    end
    exp_credit = 25;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        for (int g = 0; g < 3; g++) begin
          step();
          tests++;
          if (change_n !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL change_gap_%0d_%0d: got chg=%b busy=%b, expected 0 1", i, g, change_n, busy);
          end
        end
      end
      step();
      exp_credit -= 5;
      tests++;
      if (change_n !== 1'b1 || credit !== exp_credit[7:0] || busy !== 1'b1) begin
        fails++;
        $display("FAIL change_pulse_%0d: got chg=%b credit=%0d busy=%b, expected 1 %0d 1",
                 i, change_n, credit, busy, exp_credit);
      end
    end
    step();
    tests++;
    if (busy !== 1'b0 || change_n !== 1'b0 || credit !== 8'd0) begin
      fails++;
      $display("FAIL change_done: got busy=%b chg=%b credit=%0d, expected 0 0 0", busy, change_n, credit);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    pulse(1, 1, 1, 0, 0);
    tests++;
    if (credit !== 8'd25 || coin_reject !== 1'b1) begin
      fails++;
      $display("FAIL simul_coins: got credit=%0d rej=%b, expected 25 1", credit, coin_reject);
    end
    step();
    tests++;
    if (coin_reject !== 1'b0) begin
      fails++;
      $display("FAIL simul_reject_width: got rej=%b, expected 0", coin_reject);
    end
    pulse(0, 0, 1, 0, 0);
    step();
    pulse(0, 0, 1, 0, 0);
    step();
    pulse(0, 0, 1, 1, 0);
    tests++;
    if (dispense !== 1'b1 || coin_reject !== 1'b1 || credit !== 8'd0) begin
      fails++;
      $display("FAIL simul_sel_coin: got disp=%b rej=%b credit=%0d, expected 1 1 0", dispense, coin_reject, credit);
    end
    step();
  endtask

  task automatic test_ceiling();
    int chg_count;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      pulse(0, 0, 1, 0, 0);
      step();
    end
    pulse(0, 1, 0, 0, 0);
    step();
    pulse(1, 0, 0, 0, 0);
    step();
    tests++;
    if (credit !== 8'd190) begin
      fails++;
      $display("FAIL ceil_build: got credit=%0d, expected 190", credit);
    end
    pulse(0, 0, 1, 0, 0);
    tests++;
    if (credit !== 8'd190 || coin_reject !== 1'b1) begin
      fails++;
      $display("FAIL ceil_q_reject: got credit=%0d rej=%b, expected 190 1", credit, coin_reject);
    end
    step();
    pulse(0, 1, 0, 0, 0);
    tests++;
    if (credit !== 8'd200 || coin_reject !== 1'b0) begin
      fails++;
      $display("FAIL ceil_d_accept: got credit=%0d rej=%b, expected 200 0", credit, coin_reject);
    end
    step();
    pulse(1, 0, 0, 0, 0);
    tests++;
    if (credit !== 8'd200 || coin_reject !== 1'b1) begin
      fails++;
      $display("FAIL ceil_n_reject: got credit=%0d rej=%b, expected 200 1", credit, coin_reject);
    end

    do_reset();
    pulse(0, 0, 1, 0, 0);
    step();
    pulse(0, 0, 1, 0, 0);
    step();
    pulse(0, 0, 0, 1, 0);
    tests++;
    if (dispense !== 1'b0 || busy !== 1'b0 || credit !== 8'd50) begin
      fails++;
      $display("FAIL low_sel_ignored: got disp=%b busy=%b credit=%0d, expected 0 0 50", dispense, busy, credit);
    end
    pulse(0, 0, 0, 0, 1);
    tests++;
    if (change_n !== 1'b1 || credit !== 8'd45 || busy !== 1'b1) begin
      fails++;
      $display("FAIL cancel_first: got chg=%b credit=%0d busy=%b, expected 1 45 1", change_n, credit, busy);
    end
    chg_count = 1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (change_n === 1'b1) chg_count++;
    end
    tests++;
    if (chg_count !== 10 || credit !== 8'd0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL cancel_refund: got pulses=%0d credit=%0d busy=%b, expected 10 0 0", chg_count, credit, busy);
    end
    pulse(0, 0, 0, 0, 1);
    tests++;
    if (busy !== 1'b0 || change_n !== 1'b0) begin
      fails++;
      $display("FAIL cancel_zero: got busy=%b chg=%b, expected 0 0", busy, change_n);
    end
  endtask

  task automatic test_reset_mid_change();
    int chg_count;
    do_reset();
    pulse(0, 0, 1, 0, 0);
    step();
    pulse(0, 0, 0, 0, 1);
    step(4);
    tests++;
    if (change_n !== 1'b1 || credit !== 8'd15) begin
      fails++;
      $display("FAIL midreset_second_pulse: got chg=%b credit=%0d, expected 1 15", change_n, credit);
    end
    reset = 1'b0;
    step();
    tests++;
    if (credit !== 8'd0 || busy !== 1'b0 || change_n !== 1'b0) begin
      fails++;
      $display("FAIL midreset_clear: got credit=%0d busy=%b chg=%b, expected 0 0 0", credit, busy, change_n);
    end
    reset = 1'b1;
    chg_count = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (change_n === 1'b1 || credit !== 8'd0) chg_count++;
    end
    tests++;
    if (chg_count !== 0) begin
      fails++;
      $display("FAIL midreset_quiet: got %0d bad cycles, expected 0", chg_count);
    end
  endtask

  task automatic test_timeout();
    int bad;
    do_reset();
    pulse(0, 1, 0, 0, 0);
    bad = 0;
`ifdef VEND_TIMEOUT_EN
    for (int i = 0; i < 14; i++) begin
      step();
      if (busy !== 1'b0 || credit !== 8'd10) bad++;
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL timeout_hold: got %0d bad cycles, expected 0", bad);
    end
    step();
    tests++;
    if (change_n !== 1'b1 || credit !== 8'd5 || busy !== 1'b1) begin
      fails++;
      $display("FAIL timeout_first: got chg=%b credit=%0d busy=%b, expected 1 5 1", change_n, credit, busy);
    end
    step(4);
    tests++;
    if (change_n !== 1'b1 || credit !== 8'd0) begin
      fails++;
      $display("FAIL timeout_second: got chg=%b credit=%0d, expected 1 0", change_n, credit);
    end
    step();
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL timeout_done: got busy=%b, expected 0", busy);
    end
`else
    for (int i = 0; i < 100; i++) begin
      step();
      if (busy !== 1'b0 || credit !== 8'd10 || change_n !== 1'b0) bad++;
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL hold_credit: got %0d bad cycles, expected 0", bad);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_exact_vend();
    test_vend_change();
    test_simultaneous();
    test_ceiling();
    test_reset_mid_change();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
